// File: rtl/ariane_pkg.sv
// Shared FU opcode and the request/response payloads used by the ALU arbiter.
// Payload structs are sized for the widest config; narrower instances zero-extend into them.
package ariane_pkg;

    localparam int unsigned ARB_XLEN = 64;
    localparam int unsigned ARB_ID_W = 3;

    typedef enum logic [3:0] {
        ADD, SUB, XORL, ORL, ANDL, SLL, SRL, SRA,
        SLTS, SLTU, EQ, NE, LTS, GES, LTU, GEU
    } fu_op;

    typedef struct packed {
        fu_op                op;
        logic [ARB_XLEN-1:0] a;
        logic [ARB_XLEN-1:0] b;
        logic [ARB_ID_W-1:0] id;
    } alu_arb_req_t;

    typedef struct packed {
        logic [ARB_XLEN-1:0] result;
        logic                branch;
        logic [ARB_ID_W-1:0] id;
    } alu_arb_rsp_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin pick: first eligible index at or after ptr_i, wrapping at N-1.
// Purely combinational; no state.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_gnt_o
);

    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] idx_w;
        gnt_oh_o  = '0;
        win_idx_o = '0;
        any_gnt_o = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IDX_W'(idx);
            if (!any_gnt_o && elig_i[idx_w]) begin
                any_gnt_o       = 1'b1;
                win_idx_o       = idx_w;
                gnt_oh_o[idx_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NR_REQ requesters, round-robin, one grant per cycle.
// Response 1 cycle after grant; a full, undrained response slot blocks its requester.
module alu_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ     = 2,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned TRANS_ID_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NR_REQ-1:0]     req_valid_i,
    output logic [NR_REQ-1:0]     req_ready_o,
    input  fu_op                  req_op_i  [NR_REQ],
    input  logic [XLEN-1:0]       req_a_i   [NR_REQ],
    input  logic [XLEN-1:0]       req_b_i   [NR_REQ],
    input  logic [TRANS_ID_W-1:0] req_id_i  [NR_REQ],
    output fu_op                  alu_op_o,
    output logic [XLEN-1:0]       alu_a_o,
    output logic [XLEN-1:0]       alu_b_o,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic                  alu_branch_res_i,
    output logic [NR_REQ-1:0]     rsp_valid_o,
    input  logic [NR_REQ-1:0]     rsp_ready_i,
    output logic [XLEN-1:0]       rsp_result_o [NR_REQ],
    output logic [NR_REQ-1:0]     rsp_branch_o,
    output logic [TRANS_ID_W-1:0] rsp_id_o     [NR_REQ]
);

    localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0] elig;
    logic [NR_REQ-1:0] gnt_oh;
    logic [PTR_W-1:0]  win_idx;
    logic              any_gnt;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NR_REQ-1:0] rsp_vld_q, rsp_vld_d;
    alu_arb_req_t      win_req;
    alu_arb_rsp_t      slot_q [NR_REQ];
    alu_arb_rsp_t      slot_d [NR_REQ];

    // A slot being drained this cycle can be refilled in the same cycle.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            elig[i] = rst_ni & req_valid_i[i] & (~rsp_vld_q[i] | rsp_ready_i[i]);
        end
    end

    rr_pick #(
        .N     (NR_REQ),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .win_idx_o (win_idx),
        .any_gnt_o (any_gnt)
    );

    assign req_ready_o = gnt_oh;

    always_comb begin
        win_req = '{op: ADD, a: '0, b: '0, id: '0};
        if (any_gnt) begin
            win_req.op = req_op_i[win_idx];
            win_req.a  = ARB_XLEN'(req_a_i[win_idx]);
            win_req.b  = ARB_XLEN'(req_b_i[win_idx]);
            win_req.id = ARB_ID_W'(req_id_i[win_idx]);
        end
    end

    assign alu_op_o = win_req.op;
    assign alu_a_o  = win_req.a[XLEN-1:0];
    assign alu_b_o  = win_req.b[XLEN-1:0];

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (win_idx == PTR_W'(NR_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_comb begin
        rsp_vld_d = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            rsp_vld_d[i] = gnt_oh[i] | (rsp_vld_q[i] & ~rsp_ready_i[i]);
            slot_d[i]    = slot_q[i];
            if (gnt_oh[i]) begin
                slot_d[i] = '{result: ARB_XLEN'(alu_result_i),
                              branch: alu_branch_res_i,
                              id:     win_req.id};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            rsp_vld_q <= '0;
            for (int unsigned i = 0; i < NR_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            for (int unsigned i = 0; i < NR_REQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign rsp_valid_o = rsp_vld_q;

    always_comb begin
        rsp_branch_o = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            rsp_result_o[i] = slot_q[i].result[XLEN-1:0];
            rsp_branch_o[i] = slot_q[i].branch;
            rsp_id_o[i]     = slot_q[i].id[TRANS_ID_W-1:0];
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for single-shot grants plus
// hand sequences for contention, backpressure, drain+reload and reset.
module tb_alu_arbiter;
    import ariane_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    fu_op        req_op [2];
    logic [63:0] req_a  [2];
    logic [63:0] req_b  [2];
    logic [2:0]  req_id [2];
    fu_op        alu_op;
    logic [63:0] alu_a, alu_b, alu_res;
    logic        alu_br;
    logic [63:0] rsp_res [2];
    logic [1:0]  rsp_br;
    logic [2:0]  rsp_id  [2];

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NR_REQ(2), .XLEN(64), .TRANS_ID_W(3)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_a_i          (req_a),
        .req_b_i          (req_b),
        .req_id_i         (req_id),
        .alu_op_o         (alu_op),
        .alu_a_o          (alu_a),
        .alu_b_o          (alu_b),
        .alu_result_i     (alu_res),
        .alu_branch_res_i (alu_br),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_result_o     (rsp_res),
        .rsp_branch_o     (rsp_br),
        .rsp_id_o         (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared ALU
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (alu_op)
            ADD:  alu_res = alu_a + alu_b;
            SUB:  alu_res = alu_a - alu_b;
            XORL: alu_res = alu_a ^ alu_b;
            ORL:  alu_res = alu_a | alu_b;
            ANDL: alu_res = alu_a & alu_b;
            EQ:   alu_br  = (alu_a == alu_b);
            NE:   alu_br  = (alu_a != alu_b);
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  vld;
        fu_op        op0;
        logic [63:0] a0, b0;
        logic [2:0]  id0;
        fu_op        op1;
        logic [63:0] a1, b1;
        logic [2:0]  id1;
        logic [1:0]  gnt;
        logic [63:0] res;
        logic        br;
        logic [2:0]  id;
        logic        ptr;
    } vec_t;

    vec_t vt [8];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       w;
        logic [1:0] exp_g;

        vt[0] = '{2'b01, ADD,  64'd5,    64'd7,    3'd3, ADD,  64'd0,    64'd0,    3'd0, 2'b01, 64'd12,   1'b0, 3'd3, 1'b1};
        vt[1] = '{2'b10, ADD,  64'd0,    64'd0,    3'd0, EQ,   64'h55,   64'h55,   3'd5, 2'b10, 64'd0,    1'b1, 3'd5, 1'b0};
        vt[2] = '{2'b10, ADD,  64'd0,    64'd0,    3'd0, NE,   64'h55,   64'h55,   3'd6, 2'b10, 64'd0,    1'b0, 3'd6, 1'b0};
        vt[3] = '{2'b11, XORL, 64'hF0,   64'hFF,   3'd1, SUB,  64'd10,   64'd3,    3'd2, 2'b01, 64'h0F,   1'b0, 3'd1, 1'b1};
        vt[4] = '{2'b11, ANDL, 64'hC,    64'hA,    3'd4, ORL,  64'hC,    64'hA,    3'd7, 2'b10, 64'hE,    1'b0, 3'd7, 1'b0};
        vt[5] = '{2'b00, SUB,  64'd9,    64'd9,    3'd1, SUB,  64'd9,    64'd9,    3'd1, 2'b00, 64'd0,    1'b0, 3'd0, 1'b0};
        vt[6] = '{2'b10, ADD,  64'd0,    64'd0,    3'd0, SUB,  64'd0,    64'd1,    3'd0, 2'b10, '1,       1'b0, 3'd0, 1'b0};
        vt[7] = '{2'b01, ADD,  '1,       64'd1,    3'd7, ADD,  64'd0,    64'd0,    3'd0, 2'b01, 64'd0,    1'b0, 3'd7, 1'b1};

        // Reset: request pending during reset is held off, then accepted after release
        rst_n     = 1'b0;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = ADD; req_a[i] = '0; req_b[i] = '0; req_id[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ptr", 64'(dut.ptr_q), 64'd0);
        chk("rst_payload", rsp_res[0], 64'd0);
        rst_n = 1'b1;
        #1;
        chk("pending_after_rst", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b00;
        chk("pending_rsp", 64'(rsp_valid), 64'b01);

        // Table: each vector is one request cycle from empty slots
        do_reset();
        for (int v = 0; v < 8; v++) begin
            req_valid = vt[v].vld;
            req_op[0] = vt[v].op0; req_a[0] = vt[v].a0; req_b[0] = vt[v].b0; req_id[0] = vt[v].id0;
            req_op[1] = vt[v].op1; req_a[1] = vt[v].a1; req_b[1] = vt[v].b1; req_id[1] = vt[v].id1;
            rsp_ready = 2'b00;
            #1;
            chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vt[v].gnt));
            if (vt[v].gnt == 2'b00) begin
                chk($sformatf("v%0d_idle_op", v), 64'(alu_op), 64'(ADD));
                chk($sformatf("v%0d_idle_a", v), alu_a, 64'd0);
                chk($sformatf("v%0d_idle_b", v), alu_b, 64'd0);
            end else begin
                chk($sformatf("v%0d_alu_a", v), alu_a, vt[v].gnt[1] ? vt[v].a1 : vt[v].a0);
            end
            @(negedge clk);
            req_valid = 2'b00;
            chk($sformatf("v%0d_rsp_valid", v), 64'(rsp_valid), 64'(vt[v].gnt));
            chk($sformatf("v%0d_ptr", v), 64'(dut.ptr_q), 64'(vt[v].ptr));
            if (vt[v].gnt != 2'b00) begin
                w = vt[v].gnt[1];
                chk($sformatf("v%0d_result", v), rsp_res[w], vt[v].res);
                chk($sformatf("v%0d_branch", v), 64'(rsp_br[w]), 64'(vt[v].br));
                chk($sformatf("v%0d_id", v), 64'(rsp_id[w]), 64'(vt[v].id));
            end
            rsp_ready = 2'b11;
            @(negedge clk);
            rsp_ready = 2'b00;
            chk($sformatf("v%0d_drained", v), 64'(rsp_valid), 64'd0);
        end

        // Contention: both requesting, responses always consumed
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            chk($sformatf("cont%0d_ready", k), 64'(req_ready), 64'(exp_g));
            chk($sformatf("cont%0d_ptr", k), 64'(dut.ptr_q), 64'(k % 2));
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Backpressure on slot0 while req1 keeps streaming
        do_reset();
        req_valid = 2'b01;
        req_op[0] = ADD; req_a[0] = 64'd1; req_b[0] = 64'd2; req_id[0] = 3'd1;
        rsp_ready = 2'b00;
        #1;
        chk("bp_first_grant", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b11;
        req_op[0] = ADD; req_a[0] = 64'd100; req_b[0] = 64'd100; req_id[0] = 3'd2;
        req_op[1] = ADD; req_b[1] = 64'd1; req_id[1] = 3'd4;
        rsp_ready = 2'b10;
        for (int k = 0; k < 3; k++) begin
            req_a[1] = 64'(k);
            #1;
            chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'b10);
            chk($sformatf("bp%0d_vld0", k), 64'(rsp_valid[0]), 64'd1);
            chk($sformatf("bp%0d_res0", k), rsp_res[0], 64'd3);
            @(negedge clk);
            chk($sformatf("bp%0d_vld1", k), 64'(rsp_valid[1]), 64'd1);
            chk($sformatf("bp%0d_res1", k), rsp_res[1], 64'(k + 1));
        end

        // Drain + reload of slot0 in the same cycle
        req_valid = 2'b01;
        req_op[0] = SUB; req_a[0] = 64'd10; req_b[0] = 64'd3; req_id[0] = 3'd2;
        rsp_ready = 2'b01;
        #1;
        chk("reload_ready", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        chk("reload_vld0", 64'(rsp_valid[0]), 64'd1);
        chk("reload_res0", rsp_res[0], 64'd7);
        chk("reload_id0", 64'(rsp_id[0]), 64'd2);

        // Reset with slot1 still full
        chk("pre_rst_vld1", 64'(rsp_valid[1]), 64'd1);
        rst_n     = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("midrst_vld", 64'(rsp_valid), 64'd0);
        chk("midrst_ptr", 64'(dut.ptr_q), 64'd0);
        chk("midrst_res1", rsp_res[1], 64'd0);
        chk("midrst_id1", 64'(rsp_id[1]), 64'd0);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_vld", k), 64'(rsp_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
